store_buffer_ctrl: RTL and testbench
====================================

// Module: store_buffer_ctrl
// PURPOSE
// - Circular store buffer (SB) that allocates entries for stores at dispatch, records address/data at store
//   writeback, retires them in program order from ROB commit, and drains retired entries to the D-cache.
// - Produces sb_wb_vector_o / sb_commit_pt_o, consumed by prev_st_check to release loads behind older stores.
// PARAMETERS
// - SB_ENTRY  8   number of entries; power of 2, >=2
// - ADDR_W    32  store address width
// - DATA_W    32  store data width
// PORTS
// - clk_i             in   1                    clock
// - reset_i           in   1                    async, active-high reset
// - alloc_v_i         in   1                    dispatch requests one SB entry
// - alloc_ready_o     out  1                    entry available (not full)
// - alloc_sb_num_o    out  $clog2(SB_ENTRY)     entry index granted (tail)
// - st_wb_v_i         in   1                    store executed
// - st_wb_sb_num_i    in   $clog2(SB_ENTRY)     entry being written back
// - st_wb_addr_i      in   ADDR_W               store address
// - st_wb_data_i      in   DATA_W               store data
// - st_retire_i       in   1                    ROB commits oldest unretired store
// - flush_i           in   1                    squash all unretired entries
// - mem_v_o           out  1                    drain request to D-cache
// - mem_ready_i       in   1                    D-cache accepts drain
// - mem_addr_o        out  ADDR_W               drain address
// - mem_data_o        out  DATA_W               drain data
// - sb_wb_vector_o    out  SB_ENTRY             per entry: 1 = executed or free
// - sb_commit_pt_o    out  $clog2(SB_ENTRY)     oldest undrained entry (head)
// - empty_o           out  1                    no allocated entries
// BEHAVIOUR
// - Three pointers with extra wrap bit: head (drain), ret (retire), tail (alloc); head<=ret<=tail modulo wrap.
// - Reset: all pointers 0; sb_wb_vector_o = all 1s; alloc_ready_o=1; alloc_sb_num_o=0; mem_v_o=0;
//   sb_commit_pt_o=0; empty_o=1; entry addr/data regs need not be reset.
// - Alloc: fires when alloc_v_i && alloc_ready_o; entry tail gets wb=0, tail++ next cycle. alloc_ready_o is
//   registered-count based: full (tail-head==SB_ENTRY) blocks alloc even if a drain fires that cycle.
// - Writeback: if st_wb_v_i and entry allocated and not drained, latch addr/data, set wb=1 next cycle.
//   Writeback to a free entry is ignored. Alloc and writeback to same index same cycle cannot occur (not checked).
// - Retire: st_retire_i increments ret; only legal when ret!=tail and entry ret has wb=1; else ignored.
// - Drain: mem_v_o = (head!=ret), combinational from regs; mem_addr_o/mem_data_o = entry head.
//   On mem_v_o && mem_ready_i, head++ next cycle. mem_* held stable while mem_v_o && !mem_ready_i.
// - sb_wb_vector_o bit set at reset, on writeback; cleared only on alloc; drained entries stay 1.
// - Flush: tail <= ret (after same-cycle retire is applied); squashed entries' wb bits forced to 1;
//   flush beats same-cycle alloc (alloc dropped, alloc_sb_num_o not consumed); retired entries keep draining.
// - Same-cycle drain+retire+alloc all permitted; each pointer updates independently.
// - Wrap: index = pointer[$clog2(SB_ENTRY)-1:0]; full vs empty from wrap bit.
// - Reset mid-drain: mem_v_o drops immediately (async); in-flight drain is lost, D-cache must tolerate.
// CONFIGURATION
// - SB_STALL_CNT_EN defined: adds output sb_stall_cnt_o [31:0], reset 0, increments each cycle
//   alloc_v_i && !alloc_ready_o, saturates at 32'hFFFF_FFFF, unaffected by flush.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - Reset, then 8 allocs (SB_ENTRY=8) -> alloc_sb_num_o 0..7, alloc_ready_o=0 after 8th, sb_wb_vector_o=8'h00.
// - Writeback entries 2,0 then retire x2 with mem_ready_i=1 -> wb vec 8'h05, one drain (entry 0) then wait for
//   entry 1 wb; sb_commit_pt_o stays 1 until entry 1 written back, retired, drained.
// - Full buffer, alloc_v_i=1 + drain same cycle -> alloc refused that cycle, granted next cycle at index 0 (wrap).
// - Alloc 5, retire 2, flush_i -> tail rewinds to 2, wb bits 2..4 = 1, entries 0,1 still drain, empty_o after.
// - mem_ready_i=0 for 4 cycles with mem_v_o=1 -> mem_addr_o/mem_data_o stable, head unchanged.
// - SB_STALL_CNT_EN: full buffer, alloc_v_i held 10 cycles -> sb_stall_cnt_o=10; reset mid-run -> 0.

Source files
------------

// File: rtl/store_buffer_ctrl.sv
// Circular store buffer: allocate at dispatch, fill at writeback, retire in order, drain to D-cache.
// Optional SB_STALL_CNT_EN adds a saturating count of cycles where allocation was blocked by full.
module store_buffer_ctrl #(
    parameter int unsigned SB_ENTRY = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        alloc_v_i,
    output logic                        alloc_ready_o,
    output logic [$clog2(SB_ENTRY)-1:0] alloc_sb_num_o,
    input  logic                        st_wb_v_i,
    input  logic [$clog2(SB_ENTRY)-1:0] st_wb_sb_num_i,
    input  logic [ADDR_W-1:0]           st_wb_addr_i,
    input  logic [DATA_W-1:0]           st_wb_data_i,
    input  logic                        st_retire_i,
    input  logic                        flush_i,
    output logic                        mem_v_o,
    input  logic                        mem_ready_i,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_data_o,
    output logic [SB_ENTRY-1:0]         sb_wb_vector_o,
    output logic [$clog2(SB_ENTRY)-1:0] sb_commit_pt_o,
`ifdef SB_STALL_CNT_EN
    output logic [31:0]                 sb_stall_cnt_o,
`endif
    output logic                        empty_o
);

    localparam int unsigned IW = $clog2(SB_ENTRY);
    typedef logic [IW:0]   ptr_t;
    typedef logic [IW-1:0] idx_t;

    ptr_t                r_head, r_ret, r_tail;
    logic [SB_ENTRY-1:0] r_wb;
    logic [ADDR_W-1:0]   r_addr [SB_ENTRY];
    logic [DATA_W-1:0]   r_data [SB_ENTRY];

    ptr_t                w_count;
    logic                w_full;
    logic                w_alloc;
    idx_t                w_wb_off;
    logic                w_wb_hit;
    logic                w_retire;
    logic                w_mem_v;
    logic                w_drain;
    ptr_t                w_ret_nxt;
    ptr_t                w_tail_nxt;
    ptr_t                w_squash_cnt;
    logic [SB_ENTRY-1:0] w_squash;
    logic [SB_ENTRY-1:0] w_wb_nxt;

    assign w_count  = r_tail - r_head;
    assign w_full   = (r_tail[IW] != r_head[IW]) && (r_tail[IW-1:0] == r_head[IW-1:0]);
    // Flush wins over a same-cycle allocation; the granted index is simply not consumed.
    assign w_alloc  = alloc_v_i && !w_full && !flush_i;
    // Entry is live (allocated, not yet drained) when its distance from head is below the count.
    assign w_wb_off = st_wb_sb_num_i - r_head[IW-1:0];
    assign w_wb_hit = st_wb_v_i && ({1'b0, w_wb_off} < w_count);
    assign w_retire = st_retire_i && (r_ret != r_tail) && r_wb[r_ret[IW-1:0]];
    assign w_mem_v  = (r_head != r_ret);
    assign w_drain  = w_mem_v && mem_ready_i;

    assign w_ret_nxt    = r_ret + ptr_t'(w_retire);
    assign w_squash_cnt = r_tail - w_ret_nxt;

    always_comb begin
        w_tail_nxt = r_tail;
        if (flush_i) begin
            w_tail_nxt = w_ret_nxt;
        end else if (w_alloc) begin
            w_tail_nxt = r_tail + ptr_t'(1);
        end
    end

    always_comb begin
        w_squash = '0;
        for (int i = 0; i < SB_ENTRY; i++) begin
            w_squash[i] = flush_i &&
                ({1'b0, idx_t'(idx_t'(i) - w_ret_nxt[IW-1:0])} < w_squash_cnt);
        end
    end

    always_comb begin
        w_wb_nxt = r_wb;
        if (w_wb_hit) begin
            w_wb_nxt[st_wb_sb_num_i] = 1'b1;
        end
        if (w_alloc) begin
            w_wb_nxt[r_tail[IW-1:0]] = 1'b0;
        end
        w_wb_nxt = w_wb_nxt | w_squash;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head <= '0;
            r_ret  <= '0;
            r_tail <= '0;
            r_wb   <= '1;
        end else begin
            r_head <= r_head + ptr_t'(w_drain);
            r_ret  <= w_ret_nxt;
            r_tail <= w_tail_nxt;
            r_wb   <= w_wb_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wb_hit) begin
            r_addr[st_wb_sb_num_i] <= st_wb_addr_i;
            r_data[st_wb_sb_num_i] <= st_wb_data_i;
        end
    end

`ifdef SB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if (alloc_v_i && w_full && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign sb_stall_cnt_o = r_stall_cnt;
`endif

    assign alloc_ready_o  = !w_full;
    assign alloc_sb_num_o = r_tail[IW-1:0];
    assign mem_v_o        = w_mem_v;
    assign mem_addr_o     = r_addr[r_head[IW-1:0]];
    assign mem_data_o     = r_data[r_head[IW-1:0]];
    assign sb_wb_vector_o = r_wb;
    assign sb_commit_pt_o = r_head[IW-1:0];
    assign empty_o        = (r_head == r_tail);

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Bench for store_buffer_ctrl: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the buffer.
module tb_store_buffer_ctrl;

    localparam int N = 8;

    logic        clk_i;
    logic        reset_i;
    logic        alloc_v_i;
    logic        alloc_ready_o;
    logic [2:0]  alloc_sb_num_o;
    logic        st_wb_v_i;
    logic [2:0]  st_wb_sb_num_i;
    logic [31:0] st_wb_addr_i;
    logic [31:0] st_wb_data_i;
    logic        st_retire_i;
    logic        flush_i;
    logic        mem_v_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [7:0]  sb_wb_vector_o;
    logic [2:0]  sb_commit_pt_o;
    logic        empty_o;
`ifdef SB_STALL_CNT_EN
    logic [31:0] sb_stall_cnt_o;
`endif

    store_buffer_ctrl #(.SB_ENTRY(8), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .alloc_v_i      (alloc_v_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_sb_num_o (alloc_sb_num_o),
        .st_wb_v_i      (st_wb_v_i),
        .st_wb_sb_num_i (st_wb_sb_num_i),
        .st_wb_addr_i   (st_wb_addr_i),
        .st_wb_data_i   (st_wb_data_i),
        .st_retire_i    (st_retire_i),
        .flush_i        (flush_i),
        .mem_v_o        (mem_v_o),
        .mem_ready_i    (mem_ready_i),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .sb_wb_vector_o (sb_wb_vector_o),
        .sb_commit_pt_o (sb_commit_pt_o),
`ifdef SB_STALL_CNT_EN
        .sb_stall_cnt_o (sb_stall_cnt_o),
`endif
        .empty_o        (empty_o)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue holds live entries oldest first; the first m_nret of them are retired.
    int          q[$];
    int          m_nret;
    int          m_head;
    logic [7:0]  m_wbv;
    logic [31:0] m_addr [N];
    logic [31:0] m_data [N];
`ifdef SB_STALL_CNT_EN
    logic [31:0] m_stall;
`endif

    always @(posedge clk_i) begin
        automatic bit hit    = 1'b0;
        automatic bit ret_ok = 1'b0;
        automatic bit drain  = 1'b0;
        automatic bit alloc  = 1'b0;
        automatic int tail   = 0;
        if (reset_i) begin
            q.delete();
            m_nret = 0;
            m_head = 0;
            m_wbv  = 8'hFF;
`ifdef SB_STALL_CNT_EN
            m_stall = 0;
`endif
        end else begin
            foreach (q[j]) if (q[j] == int'(st_wb_sb_num_i)) hit = st_wb_v_i;
            ret_ok = st_retire_i && (m_nret < q.size()) && m_wbv[q[m_nret]];
            drain  = (m_nret > 0) && mem_ready_i;
            alloc  = alloc_v_i && (q.size() < N) && !flush_i;
            tail   = (m_head + q.size()) % N;
`ifdef SB_STALL_CNT_EN
            if (alloc_v_i && q.size() == N && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
            if (hit) begin
                m_wbv[st_wb_sb_num_i]  = 1'b1;
                m_addr[st_wb_sb_num_i] = st_wb_addr_i;
                m_data[st_wb_sb_num_i] = st_wb_data_i;
            end
            if (ret_ok) m_nret++;
            if (drain) begin
                void'(q.pop_front());
                m_nret--;
                m_head = (m_head + 1) % N;
            end
            if (alloc) begin
                q.push_back(tail);
                m_wbv[tail] = 1'b0;
            end
            if (flush_i) begin
                while (q.size() > m_nret) begin
                    m_wbv[q[$]] = 1'b1;
                    void'(q.pop_back());
                end
            end
        end
        #1;
        check("alloc_ready", 64'(alloc_ready_o), 64'(q.size() < N));
        check("alloc_num", 64'(alloc_sb_num_o), 64'((m_head + q.size()) % N));
        check("mem_v", 64'(mem_v_o), 64'(m_nret > 0));
        if (m_nret > 0) begin
            check("mem_addr", 64'(mem_addr_o), 64'(m_addr[q[0]]));
            check("mem_data", 64'(mem_data_o), 64'(m_data[q[0]]));
        end
        check("wb_vector", 64'(sb_wb_vector_o), 64'(m_wbv));
        check("commit_pt", 64'(sb_commit_pt_o), 64'(m_head));
        check("empty", 64'(empty_o), 64'(q.size() == 0));
`ifdef SB_STALL_CNT_EN
        check("stall_cnt", 64'(sb_stall_cnt_o), 64'(m_stall));
`endif
    end

    task automatic idle();
        alloc_v_i      = 1'b0;
        st_wb_v_i      = 1'b0;
        st_wb_sb_num_i = '0;
        st_wb_addr_i   = '0;
        st_wb_data_i   = '0;
        st_retire_i    = 1'b0;
        flush_i        = 1'b0;
        mem_ready_i    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle();
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic wb(input int num, input logic [31:0] addr, input logic [31:0] data);
        st_wb_v_i      = 1'b1;
        st_wb_sb_num_i = 3'(num);
        st_wb_addr_i   = addr;
        st_wb_data_i   = data;
    endtask

    initial begin
        idle();
        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b0;
        check("rst_ready", 64'(alloc_ready_o), 64'd1);
        check("rst_num", 64'(alloc_sb_num_o), 64'd0);
        check("rst_vec", 64'(sb_wb_vector_o), 64'hFF);
        check("rst_mem_v", 64'(mem_v_o), 64'd0);
        check("rst_empty", 64'(empty_o), 64'd1);

        // Fill all eight entries.
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clk_i);
            check("fill_num", 64'(alloc_sb_num_o), 64'(k));
            alloc_v_i = 1'b1;
        end
        @(negedge clk_i);
        check("full_ready", 64'(alloc_ready_o), 64'd0);
        check("full_vec", 64'(sb_wb_vector_o), 64'h00);
`ifdef SB_STALL_CNT_EN
        repeat (10) @(negedge clk_i);
        check("stall_10", 64'(sb_stall_cnt_o), 64'd10);
`endif
        alloc_v_i = 1'b0;

        // Out-of-order writeback; second retire blocked by entry 1.
        wb(2, 32'h0000_0200, 32'hDA7A_0002);
        @(negedge clk_i);
        wb(0, 32'h0000_0000, 32'hDA7A_0000);
        @(negedge clk_i);
        st_wb_v_i   = 1'b0;
        st_retire_i = 1'b1;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        st_retire_i = 1'b0;
        check("ooo_vec", 64'(sb_wb_vector_o), 64'h05);
        check("ooo_commit", 64'(sb_commit_pt_o), 64'd1);
        check("ooo_mem_v", 64'(mem_v_o), 64'd0);
        repeat (2) begin
            @(negedge clk_i);
            check("ooo_commit_hold", 64'(sb_commit_pt_o), 64'd1);
        end
        wb(1, 32'h0000_0100, 32'hDA7A_0001);
        @(negedge clk_i);
        st_wb_v_i   = 1'b0;
        st_retire_i = 1'b1;
        @(negedge clk_i);
        st_retire_i = 1'b0;
        @(negedge clk_i);
        check("ooo_commit_adv", 64'(sb_commit_pt_o), 64'd2);

        // Full buffer: drain and alloc in the same cycle, alloc must wait one cycle.
        do_reset();
        alloc_v_i = 1'b1;
        repeat (N) @(negedge clk_i);
        alloc_v_i = 1'b0;
        wb(0, 32'h0000_1000, 32'h1111_0000);
        @(negedge clk_i);
        st_wb_v_i   = 1'b0;
        st_retire_i = 1'b1;
        @(negedge clk_i);
        st_retire_i = 1'b0;
        alloc_v_i   = 1'b1;
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("wrap_refused_vec", 64'(sb_wb_vector_o), 64'h01);
        check("wrap_ready", 64'(alloc_ready_o), 64'd1);
        check("wrap_num", 64'(alloc_sb_num_o), 64'd0);
        @(negedge clk_i);
        alloc_v_i   = 1'b0;
        mem_ready_i = 1'b0;
        check("wrap_granted_vec", 64'(sb_wb_vector_o), 64'h00);
        check("wrap_full", 64'(alloc_ready_o), 64'd0);

        // Flush after two retires, then a stalled and resumed drain.
        do_reset();
        alloc_v_i = 1'b1;
        repeat (5) @(negedge clk_i);
        alloc_v_i = 1'b0;
        wb(0, 32'hA000_0000, 32'hD000_0000);
        @(negedge clk_i);
        wb(1, 32'hA000_0004, 32'hD000_0001);
        @(negedge clk_i);
        st_wb_v_i   = 1'b0;
        st_retire_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        st_retire_i = 1'b0;
        flush_i     = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_tail", 64'(alloc_sb_num_o), 64'd2);
        check("flush_vec", 64'(sb_wb_vector_o), 64'hFF);
        check("flush_mem_v", 64'(mem_v_o), 64'd1);
        repeat (4) begin
            @(negedge clk_i);
            check("stall_addr", 64'(mem_addr_o), 64'hA000_0000);
            check("stall_data", 64'(mem_data_o), 64'hD000_0000);
            check("stall_head", 64'(sb_commit_pt_o), 64'd0);
        end
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("drain1_addr", 64'(mem_addr_o), 64'hA000_0004);
        @(negedge clk_i);
        check("drain_empty", 64'(empty_o), 64'd1);
        check("drain_mem_v", 64'(mem_v_o), 64'd0);
        mem_ready_i = 1'b0;

        // Random traffic with occasional asynchronous reset.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if ($urandom_range(0, 399) == 0) begin
                idle();
                reset_i = 1'b1;
                #1;
                check("async_rst_mem_v", 64'(mem_v_o), 64'd0);
                check("async_rst_empty", 64'(empty_o), 64'd1);
                @(negedge clk_i);
                reset_i = 1'b0;
            end else begin
                alloc_v_i      = ($urandom_range(0, 1) == 1);
                st_wb_v_i      = ($urandom_range(0, 9) < 6);
                st_wb_sb_num_i = 3'($urandom_range(0, N - 1));
                if (alloc_v_i && st_wb_sb_num_i == alloc_sb_num_o)
                    st_wb_sb_num_i = st_wb_sb_num_i + 3'd1;
                st_wb_addr_i = $urandom;
                st_wb_data_i = $urandom;
                st_retire_i  = ($urandom_range(0, 1) == 1);
                flush_i      = ($urandom_range(0, 49) == 0);
                mem_ready_i  = ($urandom_range(0, 2) != 0);
            end
        end
        @(negedge clk_i);
        idle();
        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
